// File: rtl/axi_bram_slave.sv
// AXI4-Lite slave backed by a word-organised RAM with byte-strobed writes.
// Read and write channels run as independent FSMs; every output is registered.
module axi_bram_slave #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    input  logic [2:0]            axi_arprot,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [2:0]            axi_awprot,
    input  logic [31:0]           axi_wdata,
    input  logic [3:0]            axi_wstrb,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic [2:0]            reading_state,
    output logic [2:0]            writing_state
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_MEM  = 3'd1,
        R_RESP = 3'd2
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_WAIT_W  = 3'd1,
        W_WAIT_AW = 3'd2,
        W_WRITE   = 3'd3,
        W_RESP    = 3'd4
    } w_state_t;

    logic [31:0] ram [DEPTH];

    r_state_t         r_state_q, r_state_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             arready_q, arready_d;

    w_state_t         w_state_q, w_state_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;

    logic ar_hs, aw_hs, w_hs;
    logic unused_inputs;

    assign ar_hs = axi_arvalid & arready_q;
    assign aw_hs = axi_awvalid & awready_q;
    assign w_hs  = axi_wvalid & wready_q;

    assign unused_inputs = ^{axi_arprot, axi_awprot, axi_araddr[1:0], axi_awaddr[1:0]};

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        arready_d = arready_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    r_idx_d   = axi_araddr[ADDR_WIDTH-1:2];
                    arready_d = 1'b0;
                    r_state_d = R_MEM;
                end
            end
            R_MEM: begin
                // Sampled before this edge's RAM write, so a colliding read sees old data
                arready_d = 1'b0;
                rdata_d   = ram[r_idx_q];
                rvalid_d  = 1'b1;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                wready_d  = 1'b1;
                if (aw_hs) w_idx_d = axi_awaddr[ADDR_WIDTH-1:2];
                if (w_hs) begin
                    wdata_d = axi_wdata;
                    wstrb_d = axi_wstrb;
                end
                if (aw_hs && w_hs) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_WRITE;
                end else if (aw_hs) begin
                    awready_d = 1'b0;
                    w_state_d = W_WAIT_W;
                end else if (w_hs) begin
                    wready_d  = 1'b0;
                    w_state_d = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                awready_d = 1'b0;
                wready_d  = 1'b1;
                if (w_hs) begin
                    wdata_d   = axi_wdata;
                    wstrb_d   = axi_wstrb;
                    wready_d  = 1'b0;
                    w_state_d = W_WRITE;
                end
            end
            W_WAIT_AW: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                if (aw_hs) begin
                    w_idx_d   = axi_awaddr[ADDR_WIDTH-1:2];
                    awready_d = 1'b0;
                    w_state_d = W_WRITE;
                end
            end
            W_WRITE: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    // RAM has no reset; a write pending when reset hits is dropped
    always_ff @(posedge clk) begin
        if (!rst && w_state_q == W_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) ram[w_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign axi_arready   = arready_q;
    assign axi_rdata     = rdata_q;
    assign axi_rresp     = 2'b00;
    assign axi_rvalid    = rvalid_q;
    assign axi_awready   = awready_q;
    assign axi_wready    = wready_q;
    assign axi_bresp     = 2'b00;
    assign axi_bvalid    = bvalid_q;
    assign reading_state = r_state_q;
    assign writing_state = w_state_q;

endmodule

// File: tb/tb_axi_bram_slave.sv
// Bench for axi_bram_slave: directed AXI-Lite transactions followed by random
// traffic, all checked every cycle against a transaction-level memory model.
module tb_axi_bram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] axi_araddr, axi_awaddr;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic [2:0]  axi_arprot, axi_awprot;
    logic [31:0] axi_rdata, axi_wdata;
    logic [1:0]  axi_rresp, axi_bresp;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [2:0]  reading_state, writing_state;

    int checks = 0;
    int errors = 0;

    axi_bram_slave #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .reading_state(reading_state), .writing_state(writing_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory array plus outstanding-transaction bookkeeping.
    logic [31:0] mem_m [1024] = '{default: 32'h0};
    bit          m_seen_rst = 1'b0, m_ready_en = 1'b0;
    bit          m_rd_busy = 1'b0, m_rvalid = 1'b0;
    bit          m_have_aw = 1'b0, m_have_w = 1'b0, m_bvalid = 1'b0;
    logic [9:0]  m_rd_idx, m_wa;
    logic [31:0] m_wd, m_rdata;
    logic [3:0]  m_ws;
    bit          ar_fire = 1'b0, aw_fire = 1'b0, w_fire = 1'b0, r_fire = 1'b0, b_fire = 1'b0;

    initial begin
        bit m_ar_rdy, m_aw_rdy, m_w_rdy, capture, commit;
        int exp_rs, exp_ws;
        forever begin
            @(posedge clk);
            m_ar_rdy = m_ready_en && !m_rd_busy;
            m_aw_rdy = m_ready_en && !m_have_aw && !m_bvalid;
            m_w_rdy  = m_ready_en && !m_have_w && !m_bvalid;
            if (rst) begin
                m_seen_rst = 1'b1;
                m_ready_en = 1'b0;
                m_rd_busy = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;
                m_have_aw = 1'b0; m_have_w = 1'b0; m_bvalid = 1'b0;
                {ar_fire, aw_fire, w_fire, r_fire, b_fire} = '0;
            end else begin
                ar_fire = axi_arvalid && m_ar_rdy;
                aw_fire = axi_awvalid && m_aw_rdy;
                w_fire  = axi_wvalid && m_w_rdy;
                r_fire  = m_rvalid && axi_rready;
                b_fire  = m_bvalid && axi_bready;
                capture = m_rd_busy && !m_rvalid;
                commit  = m_have_aw && m_have_w;
                // read sees memory before any write landing on the same edge
                if (capture) begin
                    m_rdata = mem_m[m_rd_idx];
                    m_rvalid = 1'b1;
                end
                if (commit) begin
                    for (int b = 0; b < 4; b++)
                        if (m_ws[b]) mem_m[m_wa][8*b +: 8] = m_wd[8*b +: 8];
                    m_have_aw = 1'b0; m_have_w = 1'b0; m_bvalid = 1'b1;
                end
                if (r_fire) begin m_rvalid = 1'b0; m_rd_busy = 1'b0; end
                if (b_fire) m_bvalid = 1'b0;
                if (ar_fire) begin m_rd_busy = 1'b1; m_rd_idx = axi_araddr[11:2]; end
                if (aw_fire) begin m_have_aw = 1'b1; m_wa = axi_awaddr[11:2]; end
                if (w_fire) begin m_have_w = 1'b1; m_wd = axi_wdata; m_ws = axi_wstrb; end
                m_ready_en = 1'b1;
            end
            @(negedge clk);
            if (m_seen_rst) begin
                exp_rs = !m_rd_busy ? 0 : (m_rvalid ? 2 : 1);
                exp_ws = m_bvalid ? 4 : (m_have_aw && m_have_w) ? 3 : m_have_aw ? 1 : m_have_w ? 2 : 0;
                chk("arready", 32'(axi_arready), 32'(m_ready_en && !m_rd_busy));
                chk("awready", 32'(axi_awready), 32'(m_ready_en && !m_have_aw && !m_bvalid));
                chk("wready", 32'(axi_wready), 32'(m_ready_en && !m_have_w && !m_bvalid));
                chk("rvalid", 32'(axi_rvalid), 32'(m_rvalid));
                chk("bvalid", 32'(axi_bvalid), 32'(m_bvalid));
                chk("rdata", axi_rdata, m_rdata);
                chk("rresp", 32'(axi_rresp), 32'h0);
                chk("bresp", 32'(axi_bresp), 32'h0);
                chk("reading_state", 32'(reading_state), 32'(exp_rs));
                chk("writing_state", 32'(writing_state), 32'(exp_ws));
            end
        end
    end

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input int rhold);
        int rc = 0, t_ar = -1, t_rv = -1;
        bit done = 1'b0;
        axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (r_fire) done = 1'b1;
            else begin
                if (ar_fire) begin axi_arvalid = 1'b0; t_ar = t; end
                if (axi_rvalid) begin
                    if (t_rv < 0) begin
                        t_rv = t;
                        chk("rd_latency", 32'(t_rv - t_ar), 32'd1);
                    end
                    chk("rd_data", axi_rdata, exp);
                    chk("rd_arready_busy", 32'(axi_arready), 32'h0);
                    rc++;
                end
                axi_rready = rc > rhold;
            end
        end
        axi_arvalid = 1'b0; axi_rready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL rd_timeout: read of %h got no response, required one within 60 cycles", a);
        end
    endtask

    // lag > 0: W leads AW by lag cycles; lag < 0: AW leads W by -lag cycles.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lag, input int bhold);
        int aw_start = (lag > 0) ? lag : 0;
        int w_start = (lag < 0) ? -lag : 0;
        int bc = 0, t_both = -1, t_b = -1;
        bit aw_done = 1'b0, w_done = 1'b0, done = 1'b0;
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        for (int t = 0; t < 60 && !done; t++) begin
            axi_awvalid = !aw_done && t >= aw_start;
            axi_wvalid  = !w_done && t >= w_start;
            axi_bready  = bc > bhold;
            @(negedge clk);
            if (b_fire) done = 1'b1;
            else begin
                if (aw_fire) aw_done = 1'b1;
                if (w_fire) w_done = 1'b1;
                if (aw_done && w_done && t_both < 0) t_both = t;
                if (aw_done && !w_done) begin
                    chk("wait_w_state", 32'(writing_state), 32'd1);
                    chk("wait_w_awready", 32'(axi_awready), 32'd0);
                    chk("wait_w_wready", 32'(axi_wready), 32'd1);
                end
                if (w_done && !aw_done) begin
                    chk("wait_aw_state", 32'(writing_state), 32'd2);
                    chk("wait_aw_awready", 32'(axi_awready), 32'd1);
                    chk("wait_aw_wready", 32'(axi_wready), 32'd0);
                end
                if (axi_bvalid) begin
                    if (t_b < 0) begin
                        t_b = t;
                        chk("wr_latency", 32'(t_b - t_both), 32'd1);
                    end
                    chk("wr_busy_awready", 32'(axi_awready), 32'd0);
                    chk("wr_busy_wready", 32'(axi_wready), 32'd0);
                    bc++;
                end
            end
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL wr_timeout: write to %h got no response, required one within 60 cycles", a);
        end
    endtask

    function automatic logic [11:0] rand_addr();
        if ($urandom_range(3) == 0) return 12'($urandom);
        return 12'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = '0; axi_rready = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = '0;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0; axi_bready = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("arready_first_cycle", 32'(axi_arready), 32'd0);
        chk("awready_first_cycle", 32'(axi_awready), 32'd0);
        @(negedge clk);
        chk("arready_second_cycle", 32'(axi_arready), 32'd1);
        chk("wready_second_cycle", 32'(axi_wready), 32'd1);

        // Known RAM contents independent of simulator start-up values
        for (int i = 0; i < 1024; i++) wr(12'(i * 4), 32'h0, 4'hF, 0, 0);

        wr(12'h010, 32'hDEADBEEF, 4'hF, 0, 0);
        rd(12'h010, 32'hDEADBEEF, 0);
        wr(12'h010, 32'h11223344, 4'h5, 0, 0);
        rd(12'h010, 32'hDE22BE44, 0);
        wr(12'h010, 32'hAABBCCDD, 4'h0, 0, 0);
        rd(12'h010, 32'hDE22BE44, 0);

        wr(12'h040, 32'hA5A5A5A5, 4'hF, 3, 0);
        rd(12'h040, 32'hA5A5A5A5, 0);
        wr(12'h044, 32'h5A5A5A5A, 4'hF, -3, 0);
        rd(12'h044, 32'h5A5A5A5A, 0);

        rd(12'h040, 32'hA5A5A5A5, 5);
        wr(12'h048, 32'h0BADCAFE, 4'hF, 0, 5);
        rd(12'h048, 32'h0BADCAFE, 0);

        wr(12'h013, 32'hCAFEF00D, 4'hF, 0, 0);
        rd(12'h010, 32'hCAFEF00D, 0);
        wr(12'hFFC, 32'h00000001, 4'hF, 0, 0);
        rd(12'hFFF, 32'h00000001, 0);

        // Read capture and write commit on the same edge, same word
        axi_araddr = 12'h020; axi_arvalid = 1'b1;
        axi_awaddr = 12'h020; axi_wdata = 32'h12345678; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_rready = 1'b1; axi_bready = 1'b1;
        @(negedge clk);
        chk("coll_accept", 32'({ar_fire, aw_fire, w_fire}), 32'h7);
        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        @(negedge clk);
        chk("coll_rvalid", 32'(axi_rvalid), 32'd1);
        chk("coll_rdata", axi_rdata, 32'h00000000);
        @(negedge clk);
        axi_rready = 1'b0; axi_bready = 1'b0;
        rd(12'h020, 32'h12345678, 0);

        // Reset lands while the write is in its commit cycle
        axi_awaddr = 12'h030; axi_wdata = 32'hFFFFFFFF; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        @(negedge clk);
        chk("rst_wr_accept", 32'({aw_fire, w_fire}), 32'h3);
        chk("rst_wr_state", 32'(writing_state), 32'd3);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", 32'({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid}), 32'h0);
        chk("rst_rdata", axi_rdata, 32'h0);
        chk("rst_states", 32'({reading_state, writing_state}), 32'h0);
        rst = 1'b0;
        rd(12'h030, 32'h00000000, 0);

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            if (ar_fire) axi_arvalid = 1'b0;
            if (aw_fire) axi_awvalid = 1'b0;
            if (w_fire) axi_wvalid = 1'b0;
            if (!axi_arvalid && $urandom_range(2) == 0) begin
                axi_araddr = rand_addr(); axi_arprot = 3'($urandom); axi_arvalid = 1'b1;
            end
            if (!axi_awvalid && $urandom_range(2) == 0) begin
                axi_awaddr = rand_addr(); axi_awprot = 3'($urandom); axi_awvalid = 1'b1;
            end
            if (!axi_wvalid && $urandom_range(2) == 0) begin
                axi_wdata = $urandom; axi_wstrb = 4'($urandom); axi_wvalid = 1'b1;
            end
            axi_rready = $urandom_range(3) != 0;
            axi_bready = $urandom_range(3) != 0;
            @(negedge clk);
        end

        axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_rready = 1'b1; axi_bready = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required to finish by time 500000");
        $fatal(1);
    end

endmodule
